// File: rtl/shared_bus_datapath.sv
// shared_bus_datapath
//   Responder end of the control-strobe interface. Executes the per-cycle
//   strobes from the control unit on a single shared data bus:
//     - register file (r0 reads as zero, writes to r0 dropped)
//     - ALU operand latches A and B, function latch, registered result
//     - immediate injection onto the bus
//   Exactly one bus source is expected per cycle; sources resolve by fixed
//   priority imm_EN > alu_broadcast > register_read_enable.
//
//   Optional build macro: DATAPATH_BUS_CHECK_EN
//     defined   : bus_error becomes a sticky protocol-violation flag
//     undefined : bus_error is tied low, no checking logic is built
//
//   Strobe semantics: strobes are single-cycle commands sampled on the
//   rising edge of clk; there is no back-pressure. alu_busy is high for
//   exactly the cycle between an operand-B load and the result update.
module shared_bus_datapath #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 32,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int SH_W     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        alu_function_sel,
    input  logic              alu_store_1,
    input  logic              alu_store_2,
    input  logic              alu_broadcast,
    input  logic [IDX_W-1:0]  register_index,
    input  logic              register_read_enable,
    input  logic              register_write_enable,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_EN,
    output logic [DATA_W-1:0] bus_value,
    output logic              alu_busy,
    output logic              alu_zero,
    output logic              bus_error
);

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // Operation sequencer: IDLE, or EXEC for the one cycle in which an
    // operation has been issued and its result is not yet registered.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                alu_complete;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   bus_d;

    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2:0]          fcn_q, fcn_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic [DATA_W-1:0]   alu_out;
    logic [SH_W-1:0]     shamt;

    // ------------------------------------------------------------------
    // Bus resolution
    // ------------------------------------------------------------------

    // Register read port: index 0 always reads zero.
    always_comb begin
        rd_data = '0;
        if (register_index != '0) begin
            rd_data = regs_q[register_index];
        end
    end

    // Single bus source chosen by fixed priority; zero when nothing drives.
    always_comb begin
        bus_d = '0;
        if (imm_EN) begin
            bus_d = imm;
        end else if (alu_broadcast) begin
            bus_d = result_q;
        end else if (register_read_enable) begin
            bus_d = rd_data;
        end
    end

    assign bus_value = bus_d;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------

    // Registered write from the bus; r0 is never written. A read and write
    // of the same index in one cycle simply rewrites the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (register_write_enable && (register_index != '0)) begin
            regs_q[register_index] <= bus_d;
        end
    end

    // ------------------------------------------------------------------
    // Operation sequencer (three-process FSM)
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every operand-B load issues an operation, including one
    // in the completion cycle of the previous operation (back-to-back).
    always_comb begin
        state_d = ST_IDLE;
        if (alu_store_2) begin
            state_d = ST_EXEC;
        end
    end

    // Outputs of the sequencer.
    always_comb begin
        alu_busy     = 1'b0;
        alu_complete = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_busy     = 1'b1;
            alu_complete = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------

    assign shamt = b_q[SH_W-1:0];

    // Combinational ALU over the latched operands and function.
    always_comb begin
        alu_out = '0;
        case (fcn_q)
            OP_ADD:  alu_out = a_q + b_q;
            OP_SUB:  alu_out = a_q - b_q;
            OP_AND:  alu_out = a_q & b_q;
            OP_OR:   alu_out = a_q | b_q;
            OP_XOR:  alu_out = a_q ^ b_q;
            OP_SLL:  alu_out = a_q << shamt;
            OP_SRL:  alu_out = a_q >> shamt;
            OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_out = '0;
        endcase
    end

    // Next values for operand latches, function latch and result. The
    // result uses the pre-edge operands even when new ones load this edge.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        fcn_d    = fcn_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (alu_store_1) begin
            a_d = bus_d;
        end
        if (alu_store_2) begin
            b_d   = bus_d;
            fcn_d = alu_function_sel;
        end
        if (alu_complete) begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
        end
    end

    // ALU state registers; the zero flag resets high to match result = 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            fcn_q    <= OP_ADD;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            fcn_q    <= fcn_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign alu_zero = zero_q;

    // ------------------------------------------------------------------
    // Bus protocol checking
    // ------------------------------------------------------------------

`ifdef DATAPATH_BUS_CHECK_EN
    logic multi_src;
    logic early_bcast;
    logic err_q, err_d;

    // Violations: more than one source at once, or reading the result
    // while it is still being computed.
    always_comb begin
        multi_src   = (imm_EN & alu_broadcast) |
                      (imm_EN & register_read_enable) |
                      (alu_broadcast & register_read_enable);
        early_bcast = alu_broadcast & alu_busy;
        err_d       = err_q | multi_src | early_bcast;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus_error = err_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_shared_bus_datapath.sv
// Testbench for shared_bus_datapath: directed sequences followed by random
// strobes, checked every cycle against a behavioural model through an
// expected-value queue.
module tb_shared_bus_datapath;

  typedef struct packed {
    logic [31:0] bus;
    logic        busy;
    logic        zero;
    logic        err;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  alu_function_sel = '0;
  logic        alu_store_1 = 1'b0;
  logic        alu_store_2 = 1'b0;
  logic        alu_broadcast = 1'b0;
  logic [4:0]  register_index = '0;
  logic        register_read_enable = 1'b0;
  logic        register_write_enable = 1'b0;
  logic [31:0] imm = '0;
  logic        imm_EN = 1'b0;
  logic [31:0] bus_value;
  logic        alu_busy;
  logic        alu_zero;
  logic        bus_error;

  always #5 clk = ~clk;

  shared_bus_datapath dut (
    .clk                   (clk),
    .reset                 (reset),
    .alu_function_sel      (alu_function_sel),
    .alu_store_1           (alu_store_1),
    .alu_store_2           (alu_store_2),
    .alu_broadcast         (alu_broadcast),
    .register_index        (register_index),
    .register_read_enable  (register_read_enable),
    .register_write_enable (register_write_enable),
    .imm                   (imm),
    .imm_EN                (imm_EN),
    .bus_value             (bus_value),
    .alu_busy              (alu_busy),
    .alu_zero              (alu_zero),
    .bus_error             (bus_error)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_a, m_b, m_result;
  logic [2:0]  m_fcn;
  logic        m_pending, m_zero, m_err;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  logic obs_valid = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compares the DUT outputs mid-cycle whenever a cycle was issued.
  always @(negedge clk) begin
    exp_t e;
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bus_value", bus_value, e.bus);
        check("alu_busy", {31'd0, alu_busy}, {31'd0, e.busy});
        check("alu_zero", {31'd0, alu_zero}, {31'd0, e.zero});
        check("bus_error", {31'd0, bus_error}, {31'd0, e.err});
      end
    end
  end

  // ---------------- driver ----------------
  // One clock cycle of strobes: apply, push expected outputs, advance model.
  task automatic drive(input logic rst, input logic ie, input logic [31:0] iv,
                       input logic bc, input logic rd, input logic wr,
                       input logic [4:0] idx, input logic s1, input logic s2,
                       input logic [2:0] fs);
    exp_t        e;
    logic [31:0] bus;
    int          nsrc;
    @(posedge clk);
    #1;
    reset = rst; imm_EN = ie; imm = iv; alu_broadcast = bc;
    register_read_enable = rd; register_write_enable = wr; register_index = idx;
    alu_store_1 = s1; alu_store_2 = s2; alu_function_sel = fs;

    if (ie) bus = iv;
    else if (bc) bus = m_result;
    else if (rd) bus = (idx == 0) ? 32'd0 : m_regs[idx];
    else bus = 32'd0;
    e.bus  = bus;
    e.busy = m_pending;
    e.zero = m_zero;
`ifdef DATAPATH_BUS_CHECK_EN
    e.err  = m_err;
`else
    e.err  = 1'b0;
`endif
    exp_q.push_back(e);
    obs_valid = 1'b1;

    // state after the coming edge
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_a = 0; m_b = 0; m_fcn = 0; m_result = 0;
      m_pending = 0; m_zero = 1; m_err = 0;
    end else begin
      nsrc = int'(ie) + int'(bc) + int'(rd);
      if (nsrc > 1 || (bc && m_pending)) m_err = 1'b1;
      if (wr && idx != 0) m_regs[idx] = bus;
      if (m_pending) begin
        m_result = ref_alu(m_a, m_b, m_fcn);
        m_zero   = (m_result == 32'd0);
      end
      if (s1) m_a = bus;
      if (s2) begin
        m_b = bus;
        m_fcn = fs;
      end
      m_pending = s2;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_a = 0; m_b = 0; m_fcn = 0; m_result = 0;
    m_pending = 0; m_zero = 1; m_err = 0;

    // reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // r3 = 5, r4 = 7 via imm, read back r3
    drive(0, 1, 32'd5, 0, 0, 1, 5'd3, 0, 0, 0);
    drive(0, 1, 32'd7, 0, 0, 1, 5'd4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 5'd3, 0, 0, 0);

    // ADD r3 + r4 -> 12
    drive(0, 0, 0, 0, 1, 0, 5'd3, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 5'd4, 0, 1, 3'd0);
    idle();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // SUB 3 - 3 -> 0, zero flag
    drive(0, 1, 32'd3, 0, 0, 0, 0, 1, 1, 3'd1);
    idle();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // SLT -1 < 1 -> 1
    drive(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 32'd1, 0, 0, 0, 0, 0, 1, 3'd7);
    idle();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // r0 stays zero
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1, 5'd0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 5'd0, 0, 0, 0);

    // back-to-back: 1+1 then 1+2
    drive(0, 1, 32'd1, 0, 0, 0, 0, 1, 1, 3'd0);
    drive(0, 1, 32'd2, 0, 0, 0, 0, 0, 1, 3'd0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // same-index read and write is a no-op
    drive(0, 1, 32'd9, 0, 0, 1, 5'd5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 5'd5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 5'd5, 0, 0, 0);

    // clean reset, then two-source conflict, hold, and mid-sequence reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'd11, 0, 0, 1, 5'd6, 0, 0, 0);
    drive(0, 1, 32'h1234_5678, 0, 1, 0, 5'd6, 0, 0, 0);
    idle();
    idle();
    drive(1, 0, 0, 0, 1, 0, 5'd6, 1, 1, 3'd3);
    drive(0, 0, 0, 0, 1, 0, 5'd6, 0, 0, 0);

    // random strobes, mostly single-source, all opcodes and shift amounts
    for (int n = 0; n < 400; n++) begin
      logic        ie, bc, rd, wr, s1, s2, rst;
      logic [31:0] iv;
      int          src;
      rst = ($urandom_range(0, 99) == 0);
      src = $urandom_range(0, 9);
      ie = (src < 4); bc = (src == 4 || src == 5); rd = (src >= 6 && src < 9);
      if ($urandom_range(0, 19) == 0) begin ie = 1; rd = 1; end
      case ($urandom_range(0, 3))
        0: iv = $urandom_range(0, 40);
        1: iv = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: iv = $urandom;
      endcase
      wr = ($urandom_range(0, 2) == 0);
      s1 = ($urandom_range(0, 2) == 0);
      s2 = ($urandom_range(0, 2) == 0);
      drive(rst, ie, iv, bc, rd, wr, 5'($urandom_range(0, 31)), s1, s2,
            3'($urandom_range(0, 7)));
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    @(posedge clk);
    #1;
    obs_valid = 1'b0;
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
